// File: rtl/fft_bitrev_out.sv
// Output reorder stage for the pipelined radix-2 DIF FFT: takes a bit-reversed frame
// into one half of a ping-pong buffer and streams it out in natural bin order.
module fft_bitrev_out #(
  parameter int DATA_WIDTH = 16,
  parameter int FFT_N      = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sig_start_i,
  input  logic                  sig_vld_i,
  input  logic [DATA_WIDTH-1:0] sig_real_i,
  input  logic [DATA_WIDTH-1:0] sig_imag_i,
  output logic                  sig_start_o,
  output logic                  sig_vld_o,
  output logic                  sig_last_o,
  output logic [DATA_WIDTH-1:0] sig_real_o,
  output logic [DATA_WIDTH-1:0] sig_imag_o,
  output logic                  frame_err_o
);

  typedef enum logic { W_IDLE, W_FILL } w_state_t;
  typedef enum logic { R_IDLE, R_RUN  } r_state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(FFT_N - 1);
  localparam logic [ADDR_WIDTH-1:0] ONE_IDX  = ADDR_WIDTH'(1);

  function automatic logic [ADDR_WIDTH-1:0] bitrev(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < ADDR_WIDTH; i++) r[i] = a[ADDR_WIDTH-1-i];
    return r;
  endfunction

  logic [2*DATA_WIDTH-1:0] mem [2][FFT_N];

  w_state_t              w_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0] wcnt, wcnt_nxt;
  logic                  wbank, wbank_nxt;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_idx;
  logic                  rd_req, rd_req_nxt;
  logic                  err_nxt;

  r_state_t              r_state, r_state_nxt;
  logic [ADDR_WIDTH-1:0] rcnt, rcnt_nxt;
  logic                  rbank, rbank_nxt;
  logic                  rd_active;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  rd_bank;
  logic [2*DATA_WIDTH-1:0] rd_word;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state     <= W_IDLE;
      wcnt        <= '0;
      wbank       <= 1'b0;
      rd_req      <= 1'b0;
      frame_err_o <= 1'b0;
    end else begin
      w_state     <= w_state_nxt;
      wcnt        <= wcnt_nxt;
      wbank       <= wbank_nxt;
      rd_req      <= rd_req_nxt;
      frame_err_o <= err_nxt;
    end
  end

  // A start seen mid-fill restarts the frame in the same bank; the partial data is simply overwritten.
  always_comb begin
    w_state_nxt = w_state;
    wcnt_nxt    = wcnt;
    wbank_nxt   = wbank;
    wr_en       = 1'b0;
    wr_idx      = wcnt;
    rd_req_nxt  = 1'b0;
    err_nxt     = 1'b0;
    if (sig_vld_i) begin
      case (w_state)
        W_IDLE: begin
          if (sig_start_i) begin
            wr_en       = 1'b1;
            wr_idx      = '0;
            wcnt_nxt    = ONE_IDX;
            w_state_nxt = W_FILL;
          end
        end
        W_FILL: begin
          wr_en = 1'b1;
          if (sig_start_i) begin
            wr_idx   = '0;
            wcnt_nxt = ONE_IDX;
            err_nxt  = 1'b1;
          end else begin
            wr_idx   = wcnt;
            wcnt_nxt = wcnt + ONE_IDX;
            if (wcnt == LAST_IDX) begin
              rd_req_nxt  = 1'b1;
              wbank_nxt   = ~wbank;
              w_state_nxt = W_IDLE;
            end
          end
        end
        default: w_state_nxt = W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wbank][bitrev(wr_idx)] <= {sig_real_i, sig_imag_i};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= R_IDLE;
      rcnt    <= '0;
      rbank   <= 1'b0;
    end else begin
      r_state <= r_state_nxt;
      rcnt    <= rcnt_nxt;
      rbank   <= rbank_nxt;
    end
  end

  // rd_req addresses bin 0 directly in its own cycle, so the bank just completed
  // (already toggled away from the write pointer) is read with no bubble.
  always_comb begin
    r_state_nxt = r_state;
    rcnt_nxt    = rcnt;
    rbank_nxt   = rbank;
    rd_active   = rd_req || (r_state == R_RUN);
    rd_addr     = rd_req ? '0 : rcnt;
    rd_bank     = rd_req ? ~wbank : rbank;
    if (rd_req) begin
      r_state_nxt = R_RUN;
      rcnt_nxt    = ONE_IDX;
      rbank_nxt   = ~wbank;
    end else if (r_state == R_RUN) begin
      rcnt_nxt = rcnt + ONE_IDX;
      if (rcnt == LAST_IDX) r_state_nxt = R_IDLE;
    end
  end

  assign rd_word = mem[rd_bank][rd_addr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_vld_o   <= 1'b0;
      sig_start_o <= 1'b0;
      sig_last_o  <= 1'b0;
      sig_real_o  <= '0;
      sig_imag_o  <= '0;
    end else begin
      sig_vld_o   <= rd_active;
      sig_start_o <= rd_active && (rd_addr == '0);
      sig_last_o  <= rd_active && (rd_addr == LAST_IDX);
      sig_real_o  <= rd_active ? rd_word[2*DATA_WIDTH-1:DATA_WIDTH] : '0;
      sig_imag_o  <= rd_active ? rd_word[DATA_WIDTH-1:0] : '0;
    end
  end

endmodule

// File: doc/fft_bitrev_out.md
# fft_bitrev_out

Output reorder stage placed after the last `fft_stage_n1_opt` stage of the pipelined radix-2 DIF FFT. It receives one frame of FFT_N complex bins in bit-reversed order (sample k carries bin bitrev(k)) and re-emits the frame in natural bin order. It uses an internal ping-pong register buffer of 2×FFT_N words. Readout runs at one word per cycle, so contiguous back-to-back frames stream with no stall and no backpressure.

## Interface
- DATA_WIDTH, 16, width of each real/imag component
- FFT_N, 16, frame length (power of two, ≥4)
- ADDR_WIDTH, 4, log2(FFT_N)
- clk  input  1  clock, all logic on rising edge
- rst_n  input  1  asynchronous active-low reset
- sig_start_i  input  1  marks first sample of a frame; only meaningful with sig_vld_i=1
- sig_vld_i  input  1  input sample valid
- sig_real_i  input  DATA_WIDTH  input real part
- sig_imag_i  input  DATA_WIDTH  input imag part
- sig_start_o  output  1  high with output bin 0
- sig_vld_o  output  1  output sample valid
- sig_last_o  output  1  high with output bin FFT_N-1
- sig_real_o  output  DATA_WIDTH  output real part
- sig_imag_o  output  DATA_WIDTH  output imag part
- frame_err_o  output  1  one-cycle pulse: frame aborted by an early sig_start_i

## Operation
- Write side FSM: W_IDLE, W_FILL. Write counter wcnt is ADDR_WIDTH bits. Write bank pointer wbank is 1 bit.
- Sample accepted = sig_vld_i=1 in a cycle.
- W_IDLE:
  - Accepted samples without sig_start_i are dropped.
  - Accepted sample with sig_start_i is written to mem[wbank][bitrev(0)]. Then wcnt←1, go to W_FILL.
- W_FILL, accepted sample without start:
  - Write to mem[wbank][bitrev(wcnt)], then wcnt←wcnt+1.
  - If wcnt was FFT_N-1, the frame is complete: issue rd_req, toggle wbank, return to W_IDLE.
- W_FILL, accepted sample with start:
  - Pulse frame_err_o next cycle and discard the partial frame.
  - Write the new sample to mem[wbank][bitrev(0)] with the same bank, then wcnt←1 and stay in W_FILL.
- bitrev reverses all ADDR_WIDTH bits of the index.
- Cycles with sig_vld_i=0 are gaps. State is held; no write occurs.
- Read side FSM: R_IDLE, R_RUN. Read counter rcnt is ADDR_WIDTH bits. Read bank rbank = the bank just completed.
- rd_req (registered) moves the read FSM to R_RUN with rcnt=0, from either state. This happens even in the cycle after rcnt=FFT_N-1, which gives back-to-back frames.
- R_RUN reads mem[rbank][rcnt] into the output registers and increments rcnt. After rcnt=FFT_N-1 it returns to R_IDLE unless a new rd_req is present.
- Output registers are loaded every cycle:
  - sig_vld_o = 1 while reading, else 0.
  - sig_start_o = 1 when rcnt=0.
  - sig_last_o = 1 when rcnt=FFT_N-1.
  - Data = memory word when valid, else 0.
- A bank cannot be overwritten while it is being read. A frame needs at least FFT_N accepted cycles, and readout lasts exactly FFT_N cycles. No overflow logic is required.
- Data passes through unmodified: no scaling or rounding.

## Timing
- Reset (asynchronous, rst_n=0):
  - All outputs 0.
  - FSMs go to W_IDLE and R_IDLE; wcnt=rcnt=0, wbank=0.
  - Buffer contents need not be cleared.
- Latency: last sample of a frame accepted in cycle T. rd_req is high in T+1, and read index 0 is addressed in T+1. Output bin 0 appears (sig_vld_o=sig_start_o=1) in T+2. Output bin FFT_N-1 appears in T+FFT_N+1 with sig_last_o=1.
- Output is a contiguous burst of FFT_N valid cycles, with no gaps even if the input was gapped.
- Back-to-back input frames (next last sample at T+FFT_N) give output bursts with no idle cycle between them.
- frame_err_o is high in the cycle after the offending start sample, for 1 cycle.
- A reset asserted mid-fill or mid-readout aborts immediately; the outputs are 0 in the reset cycle. After release, the block needs a fresh sig_start_i.
- An aborted frame never produces rd_req. A readout already in R_RUN continues unaffected by an abort on the write side.

## Test plan
- Single frame, FFT_N=16, input real=k, imag=−k for k=0..15 contiguous:
  - Output real sequence is 0,8,4,12,2,10,6,14,1,9,5,13,3,11,7,15 and imag is its negation.
  - sig_start_o appears 2 cycles after the last input, sig_last_o on the 16th output.
- Three back-to-back frames with distinct data: 48 consecutive sig_vld_o cycles, sig_start_o at output cycles 0, 16 and 32, each frame correctly reordered.
- Same frame with a 1-cycle gap after every input: output is still 16 contiguous valid cycles, starting 2 cycles after the last input.
- Frame aborted at k=5 by a new sig_start_i:
  - frame_err_o pulses once.
  - Only the new frame is output, with none of the 5 stale samples.
- 3 valid samples before any sig_start_i, then a normal frame: the 3 samples are ignored and output equals the single-frame case.
- rst_n pulled low at output bin 7: all outputs are 0 immediately. After release, a new frame is reordered correctly with no remnants.
